// File: rtl/background_block_writer_pkg.sv
// Shared constants and types for the background block memory.
// Used by the write-side controller and the read-side address generator.
package background_block_writer_pkg;

    localparam int unsigned N_COLS      = 80;
    localparam int unsigned N_ROWS      = 60;
    localparam int unsigned BLOCK_COUNT = N_COLS * N_ROWS;
    localparam int unsigned LAST_ADDR   = BLOCK_COUNT - 1;
    localparam int unsigned ADDR_W      = 13;
    localparam int unsigned DATA_W      = 9;
    localparam int unsigned COL_W       = 7;
    localparam int unsigned ROW_W       = 6;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_FILL  = 1'b1
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

    // True when (col, row) lies inside the visible block grid.
    function automatic logic block_in_range(input logic [COL_W-1:0] col,
                                            input logic [ROW_W-1:0] row);
        return (col < COL_W'(N_COLS)) && (row < ROW_W'(N_ROWS));
    endfunction

endpackage

// File: rtl/background_block_writer_block_addr_calc.sv
// Combinational (row, col) -> row*80 + col block address, built from shifts and adds.
module block_addr_calc
    import background_block_writer_pkg::*;
#(
    parameter int unsigned size_address = ADDR_W,
    parameter int unsigned col_w        = COL_W,
    parameter int unsigned row_w        = ROW_W
) (
    input  logic [row_w-1:0]        row_i,
    input  logic [col_w-1:0]        col_i,
    output logic [size_address-1:0] addr_c_o
);

    logic [size_address-1:0] row_ext;
    logic [size_address-1:0] col_ext;

    assign row_ext = size_address'(row_i);
    assign col_ext = size_address'(col_i);

    // row*64 + row*16 = row*80; max result 4799 fits in 13 bits
    assign addr_c_o = (row_ext << 6) + (row_ext << 4) + col_ext;

endmodule

// File: rtl/background_block_writer.sv
// Write-side controller for the background block RAM: single-block writes
// and full-screen fills driven onto the RAM write port.
module background_block_writer
    import background_block_writer_pkg::*;
#(
    parameter int unsigned size_address = ADDR_W,
    parameter int unsigned size_data    = DATA_W,
    parameter int unsigned n_cols       = N_COLS,
    parameter int unsigned n_rows       = N_ROWS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_opcode,
    input  logic [COL_W-1:0]        cmd_col,
    input  logic [ROW_W-1:0]        cmd_row,
    input  logic [size_data-1:0]    cmd_data,
    output logic                    mem_we,
    output logic [size_address-1:0] mem_addr,
    output logic [size_data-1:0]    mem_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [size_address-1:0] LAST_A = size_address'(n_cols * n_rows - 1);
    localparam logic [size_address-1:0] PRE_LAST_A = size_address'(n_cols * n_rows - 2);
    localparam logic [COL_W-1:0] COL_LIM = COL_W'(n_cols);
    localparam logic [ROW_W-1:0] ROW_LIM = ROW_W'(n_rows);

    state_e                  state_q, state_d;
    logic                    mem_we_q, mem_we_d;
    logic [size_address-1:0] mem_addr_q, mem_addr_d;
    logic [size_data-1:0]    mem_data_q, mem_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [size_address-1:0] blk_addr_c;
    logic                    in_range_c;

    block_addr_calc #(
        .size_address (size_address),
        .col_w        (COL_W),
        .row_w        (ROW_W)
    ) u_addr_calc (
        .row_i    (cmd_row),
        .col_i    (cmd_col),
        .addr_c_o (blk_addr_c)
    );

    assign in_range_c = (cmd_col < COL_LIM) && (cmd_row < ROW_LIM);
    assign cmd_ready  = (state_q == ST_IDLE);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next state and next outputs; address/data hold while idle
    always_comb begin
        state_d    = state_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_opcode == OP_FILL) begin
                        state_d    = ST_FILL;
                        mem_we_d   = 1'b1;
                        mem_addr_d = '0;
                        mem_data_d = cmd_data;
                    end else if (in_range_c) begin
                        state_d    = ST_WRITE;
                        mem_we_d   = 1'b1;
                        mem_addr_d = blk_addr_c;
                        mem_data_d = cmd_data;
                        done_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_FILL: begin
                if (mem_addr_q == LAST_A) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = mem_addr_q + size_address'(1);
                    done_d     = (mem_addr_q == PRE_LAST_A);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FILL);
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_background_block_writer.sv
// Self-checking bench for background_block_writer: transaction-level model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_background_block_writer;

    localparam int NC = 80;
    localparam int NR = 60;
    localparam int NB = NC * NR;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_opcode = 1'b0;
    logic [6:0]  cmd_col = '0;
    logic [5:0]  cmd_row = '0;
    logic [8:0]  cmd_data = '0;
    logic        cmd_ready;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [8:0]  mem_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    background_block_writer #(
        .size_address (13),
        .size_data    (9),
        .n_cols       (80),
        .n_rows       (60)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_col    (cmd_col),
        .cmd_row    (cmd_row),
        .cmd_data   (cmd_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Model: occ counts cycles the block stays occupied by the current command
    int          occ = 0;
    bit          is_fill = 1'b0;
    logic        e_we = 1'b0;
    logic [12:0] e_addr = '0;
    logic [8:0]  e_data = '0;
    logic        e_busy = 1'b0;
    logic        e_done = 1'b0;
    logic        e_err = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ = 0; is_fill = 1'b0;
            e_we = 1'b0; e_addr = '0; e_data = '0;
            e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        end else if (occ == 0) begin
            e_we = 1'b0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0;
            if (cmd_valid) begin
                if (cmd_opcode) begin
                    occ = NB; is_fill = 1'b1;
                    e_we = 1'b1; e_addr = '0; e_data = cmd_data; e_busy = 1'b1;
                end else if (int'(cmd_col) < NC && int'(cmd_row) < NR) begin
                    occ = 1; is_fill = 1'b0;
                    e_we = 1'b1; e_addr = 13'(int'(cmd_row) * NC + int'(cmd_col));
                    e_data = cmd_data; e_done = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
        end else begin
            occ = occ - 1;
            e_err = 1'b0;
            if (is_fill && occ > 0) begin
                e_addr = 13'(NB - occ);
                e_we = 1'b1; e_busy = 1'b1;
                e_done = ((NB - occ) == NB - 1);
            end else begin
                e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic e_ready;
        e_ready = (occ == 0);
        n_checks++;
        if ({cmd_ready, mem_we, mem_addr, mem_data, busy, done, err} !==
            {e_ready, e_we, e_addr, e_data, e_busy, e_done, e_err}) begin
            $display("FAIL model t=%0t got rdy=%b we=%b addr=%0d data=%h busy=%b done=%b err=%b expected rdy=%b we=%b addr=%0d data=%h busy=%b done=%b err=%b",
                     $time, cmd_ready, mem_we, mem_addr, mem_data, busy, done, err,
                     e_ready, e_we, e_addr, e_data, e_busy, e_done, e_err);
        end else begin
            n_pass++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Present a command, wait (bounded) until accepted, return one cycle after the accepting edge
    task automatic issue(input bit op, input int col, input int row, input int data);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = op;
        cmd_col = 7'(col); cmd_row = 6'(row); cmd_data = 9'(data);
        n = 0;
        while (!cmd_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) chk("accept_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, gaps, nbusy, ndone, done_addr, n;

        // Reset held with random inputs
        repeat (5) begin
            @(negedge clk);
            cmd_valid = 1'($urandom); cmd_opcode = 1'($urandom);
            cmd_col = 7'($urandom); cmd_row = 6'($urandom); cmd_data = 9'($urandom);
        end
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_flags", int'({busy, done, err}), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b1;

        // Single write (5,2)
        issue(1'b0, 5, 2, 'h1FF);
        chk("w1_we", int'(mem_we), 1);
        chk("w1_addr", int'(mem_addr), 165);
        chk("w1_data", int'(mem_data), 'h1FF);
        chk("w1_done", int'(done), 1);
        chk("w1_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        chk("w1_ready_back", int'(cmd_ready), 1);
        chk("w1_we_off", int'(mem_we), 0);

        // Corners
        issue(1'b0, 0, 0, 'h03C);
        chk("corner00_addr", int'(mem_addr), 0);
        issue(1'b0, 79, 59, 'h155);
        chk("corner7959_addr", int'(mem_addr), 4799);
        chk("corner7959_we", int'(mem_we), 1);

        // Back-to-back: valid held high
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 1'b0;
        nw = 0;
        for (int i = 0; i < 20; i++) begin
            cmd_col = 7'($urandom_range(0, NC - 1));
            cmd_row = 6'($urandom_range(0, NR - 1));
            cmd_data = 9'($urandom);
            @(negedge clk);
            nw += int'(mem_we);
        end
        cmd_valid = 1'b0;
        chk("b2b_writes", nw, 10);

        // Out of range
        issue(1'b0, 80, 0, 7);
        chk("oor_col_err", int'(err), 1);
        chk("oor_col_we", int'(mem_we), 0);
        chk("oor_col_ready", int'(cmd_ready), 1);
        issue(1'b0, 0, 60, 7);
        chk("oor_row_err", int'(err), 1);
        chk("oor_row_we", int'(mem_we), 0);
        chk("oor_row_ready", int'(cmd_ready), 1);

        // Fill with a single write held off until the fill completes
        issue(1'b1, 9, 9, 'h0A5);
        cmd_valid = 1'b1; cmd_opcode = 1'b0;
        cmd_col = 7'd3; cmd_row = 6'd1; cmd_data = 9'h12A;
        gaps = 0; nbusy = 0; ndone = 0; done_addr = -1;
        for (int i = 0; i < NB; i++) begin
            if (mem_we !== 1'b1 || mem_addr !== 13'(i) || mem_data !== 9'h0A5) gaps++;
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin ndone++; done_addr = int'(mem_addr); end
            @(negedge clk);
        end
        chk("fill_gaps", gaps, 0);
        chk("fill_busy_cycles", nbusy, NB);
        chk("fill_done_count", ndone, 1);
        chk("fill_done_addr", done_addr, 4799);
        chk("fill_after_ready", int'(cmd_ready), 1);
        chk("fill_after_busy", int'(busy), 0);
        chk("fill_after_we", int'(mem_we), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("held_we", int'(mem_we), 1);
        chk("held_addr", int'(mem_addr), 83);
        chk("held_data", int'(mem_data), 'h12A);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_opcode = ($urandom_range(0, 99) == 0);
            cmd_col = 7'($urandom_range(0, 90));
            cmd_row = 6'($urandom_range(0, 63));
            cmd_data = 9'($urandom);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (!cmd_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("random_drain", int'(n < 6000), 1);

        // Reset in the middle of a fill
        issue(1'b1, 0, 0, 'h0F0);
        repeat (1000) @(negedge clk);
        chk("midfill_addr", int'(mem_addr), 1000);
        chk("midfill_busy", int'(busy), 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_now_we", int'(mem_we), 0);
        chk("rst_now_busy", int'(busy), 0);
        chk("rst_now_addr", int'(mem_addr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b1; cmd_opcode = 1'b0;
        cmd_col = 7'd1; cmd_row = 6'd0; cmd_data = 9'h1C7;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("post_rst_we", int'(mem_we), 1);
        chk("post_rst_addr", int'(mem_addr), 1);
        chk("post_rst_data", int'(mem_data), 'h1C7);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
